// File: rtl/fft_frame_streamer.sv
// ---------------------------------------------------------------------------
// fft_frame_streamer
//
// Captures one complete result frame from one of three FFT engines
// (MIN_N, 2*MIN_N or 4*MIN_N points) into a register buffer and streams it
// out one complex bin per cycle over a valid/ready interface. With BITREV=1
// the engines deliver bins in bit-reversed order and the block emits them
// in natural order.
//
// Ports:
//   clk_i         clock
//   rst_i         synchronous active-high reset
//   src0_data_i   MIN_N-point frame,   bin k at [k*2*DATA_W +: 2*DATA_W]
//   src0_valid_i  src0 frame valid
//   src1_data_i   2*MIN_N-point frame
//   src1_valid_i  src1 frame valid
//   src2_data_i   4*MIN_N-point frame
//   src2_valid_i  src2 frame valid
//   src_ready_o   a frame can be accepted this cycle
//   out_data_o    {real, imag} of the current bin
//   out_index_o   natural bin index k
//   out_size_o    size code: 0 = MIN_N, 1 = 2*MIN_N, 2 = 4*MIN_N
//   out_valid_o   bin valid
//   out_last_o    current bin is k = N-1
//   out_ready_i   downstream accepts the bin
//   drop_o        sticky: a presented frame was discarded
// ---------------------------------------------------------------------------
module fft_frame_streamer #(
    parameter int DATA_W = 16,
    parameter int MIN_N  = 8,
    parameter int BITREV = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [MIN_N*2*DATA_W-1:0]     src0_data_i,
    input  logic                          src0_valid_i,
    input  logic [2*MIN_N*2*DATA_W-1:0]   src1_data_i,
    input  logic                          src1_valid_i,
    input  logic [4*MIN_N*2*DATA_W-1:0]   src2_data_i,
    input  logic                          src2_valid_i,
    output logic                          src_ready_o,
    output logic [2*DATA_W-1:0]           out_data_o,
    output logic [$clog2(4*MIN_N)-1:0]    out_index_o,
    output logic [1:0]                    out_size_o,
    output logic                          out_valid_o,
    output logic                          out_last_o,
    input  logic                          out_ready_i,
    output logic                          drop_o
);

    localparam int MAX_N = 4 * MIN_N;
    localparam int IDX_W = $clog2(MAX_N);
    localparam int BIN_W = 2 * DATA_W;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       size_reg, size_next;
    logic             drop_reg, drop_next;
    logic             capture;

    logic [BIN_W-1:0] buf_reg [MAX_N];
    logic [BIN_W-1:0] cap_val [MAX_N];

    logic             any_valid;
    logic             multi_valid;
    logic [1:0]       sel_size;
    logic [IDX_W-1:0] last_idx;
    logic [IDX_W-1:0] cnt_rev;
    logic [IDX_W-1:0] rd_addr;

    assign any_valid   = src0_valid_i | src1_valid_i | src2_valid_i;
    assign multi_valid = (src0_valid_i & src1_valid_i) |
                         (src0_valid_i & src2_valid_i) |
                         (src1_valid_i & src2_valid_i);
    assign sel_size    = src0_valid_i ? 2'd0 : (src1_valid_i ? 2'd1 : 2'd2);

    always_comb begin
        case (size_reg)
            2'd0:    last_idx = IDX_W'(MIN_N - 1);
            2'd1:    last_idx = IDX_W'(2 * MIN_N - 1);
            default: last_idx = IDX_W'(MAX_N - 1);
        endcase
    end

    // Per-entry capture value: the winning source's bin, or zero for entries
    // beyond that source's frame length.
    generate
        for (genvar gi = 0; gi < MAX_N; gi++) begin : g_cap
            logic [BIN_W-1:0] bin0, bin1, bin2;
            if (gi < MIN_N) begin : g_s0
                assign bin0 = src0_data_i[gi*BIN_W +: BIN_W];
            end else begin : g_s0z
                assign bin0 = '0;
            end
            if (gi < 2 * MIN_N) begin : g_s1
                assign bin1 = src1_data_i[gi*BIN_W +: BIN_W];
            end else begin : g_s1z
                assign bin1 = '0;
            end
            assign bin2 = src2_data_i[gi*BIN_W +: BIN_W];
            assign cap_val[gi] = src0_valid_i ? bin0 : (src1_valid_i ? bin1 : bin2);
        end
    endgenerate

    // Buffer contents are meaningless until a capture, so no reset.
    always_ff @(posedge clk_i) begin
        if (capture) begin
            for (int i = 0; i < MAX_N; i++) begin
                buf_reg[i] <= cap_val[i];
            end
        end
    end

    // Reversing the full counter width then shifting right by
    // (log2(MAX_N) - log2(N)) = (2 - size) gives the reversal over log2(N)
    // bits, since counter bits above log2(N) are always zero.
    generate
        for (genvar gi = 0; gi < IDX_W; gi++) begin : g_rev
            assign cnt_rev[gi] = cnt_reg[IDX_W-1-gi];
        end
        if (BITREV != 0) begin : g_rd_rev
            logic [1:0] shift_amt;
            assign shift_amt = 2'd2 - size_reg;
            assign rd_addr   = cnt_rev >> shift_amt;
        end else begin : g_rd_nat
            assign rd_addr = cnt_reg;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            size_reg  <= 2'd0;
            drop_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            size_reg  <= size_next;
            drop_reg  <= drop_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        size_next   = size_reg;
        drop_next   = drop_reg;
        capture     = 1'b0;
        src_ready_o = 1'b0;
        out_valid_o = 1'b0;
        out_last_o  = 1'b0;
        case (state_reg)
            IDLE: begin
                src_ready_o = 1'b1;
                if (any_valid) begin
                    capture    = 1'b1;
                    size_next  = sel_size;
                    cnt_next   = '0;
                    state_next = STREAM;
                    if (multi_valid) begin
                        drop_next = 1'b1;
                    end
                end
            end
            STREAM: begin
                out_valid_o = 1'b1;
                out_last_o  = (cnt_reg == last_idx);
                if (any_valid) begin
                    drop_next = 1'b1;
                end
                if (out_ready_i) begin
                    if (cnt_reg == last_idx) begin
                        // Counter returns to zero so the index reads 0 when idle.
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign out_data_o  = (state_reg == STREAM) ? buf_reg[rd_addr] : '0;
    assign out_index_o = cnt_reg;
    assign out_size_o  = size_reg;
    assign drop_o      = drop_reg;

endmodule
